// File: rtl/nic_port_scheduler.sv
// nic_port_scheduler
//
// Sequencer that owns the CPU-side port of one mesh node's NIC and shares it
// between a transmit client and a receive client. It polls the NIC output and
// input status registers, writes outbound packets into the NIC output buffer
// and drains inbound packets into a held receive register. The two directions
// are served round-robin when both are eligible.
//
// Ports:
//   clk        single clock, rising-edge state updates
//   reset      asynchronous, active-low
//   sched_en   1 = start new transactions, 0 = finish current one then idle
//   tx_valid   transmit packet offered
//   tx_data    transmit packet (held stable until tx_ready)
//   tx_ready   one-cycle accept pulse; tx_data is written to the NIC that cycle
//   rx_valid   receive register holds a packet
//   rx_data    received packet
//   rx_ready   receive client consumes the packet when rx_valid=1
//   nic_addr   00 input buf, 01 input status, 10 output buf, 11 output status
//   nicEn      NIC access strobe
//   nicEnWR    1 = write, 0 = read
//   nic_d_in   write data to the NIC
//   nic_d_out  NIC read data, valid the cycle after the read strobe
//   busy       scheduler is not idle
//   tx_cnt     packets written to the NIC (wrapping)
//   rx_cnt     packets read from the NIC (wrapping)

module nic_port_scheduler #(
  parameter int PACKET_WIDTH = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sched_en,
  input  logic                    tx_valid,
  input  logic [PACKET_WIDTH-1:0] tx_data,
  output logic                    tx_ready,
  output logic                    rx_valid,
  output logic [PACKET_WIDTH-1:0] rx_data,
  input  logic                    rx_ready,
  output logic [1:0]              nic_addr,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic [PACKET_WIDTH-1:0] nic_d_in,
  input  logic [PACKET_WIDTH-1:0] nic_d_out,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    tx_cnt,
  output logic [CNT_WIDTH-1:0]    rx_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    O_REQ,
    O_CHK,
    O_WR,
    I_REQ,
    I_CHK,
    B_REQ,
    B_CAP
  } state_e;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  state_e                  state_q, state_d;
  logic                    last_tx_q, last_tx_d;   // 1 = tx was served last
  logic                    rx_valid_q, rx_valid_d;
  logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_WIDTH-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0]    rx_cnt_q, rx_cnt_d;

  logic tx_elig;
  logic rx_elig;

  // The receive side is only eligible while the holding register is empty,
  // which leaves unread packets in the NIC as natural back-pressure.
  assign tx_elig = tx_valid;
  assign rx_elig = !rx_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_tx_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_tx_q  <= last_tx_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // Status bit arrives on nic_d_out in the *_CHK state, one cycle after the
  // *_REQ read strobe. The consume-clear is applied before the case because
  // B_CAP is only reachable with rx_valid low, so the two never collide.
  always_comb begin
    state_d    = state_q;
    last_tx_d  = last_tx_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (sched_en) begin
          if (tx_elig && (!rx_elig || !last_tx_q)) begin
            state_d = O_REQ;
          end else if (rx_elig) begin
            state_d = I_REQ;
          end
        end
      end
      O_REQ: state_d = O_CHK;
      O_CHK: begin
        last_tx_d = 1'b1;
        if (tx_valid && !nic_d_out[0]) begin
          state_d = O_WR;
        end else begin
          state_d = IDLE;
        end
      end
      O_WR: begin
        tx_cnt_d = tx_cnt_q + CNT_WIDTH'(1);
        state_d  = IDLE;
      end
      I_REQ: state_d = I_CHK;
      I_CHK: begin
        last_tx_d = 1'b0;
        state_d   = nic_d_out[0] ? B_REQ : IDLE;
      end
      B_REQ: state_d = B_CAP;
      B_CAP: begin
        rx_data_d  = nic_d_out;
        rx_valid_d = 1'b1;
        rx_cnt_d   = rx_cnt_q + CNT_WIDTH'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NIC strobes are a pure decode of the state register so that no input
  // can ripple combinationally onto the NIC port.
  always_comb begin
    nicEn    = 1'b0;
    nicEnWR  = 1'b0;
    nic_addr = 2'b00;
    tx_ready = 1'b0;
    nic_d_in = '0;
    unique case (state_q)
      O_REQ: begin
        nicEn    = 1'b1;
        nic_addr = ADDR_OUT_STAT;
      end
      O_WR: begin
        nicEn    = 1'b1;
        nicEnWR  = 1'b1;
        nic_addr = ADDR_OUT_BUF;
        nic_d_in = tx_data;
        tx_ready = 1'b1;
      end
      I_REQ: begin
        nicEn    = 1'b1;
        nic_addr = ADDR_IN_STAT;
      end
      B_REQ: begin
        nicEn    = 1'b1;
        nic_addr = ADDR_IN_BUF;
      end
      default: begin
        nicEn    = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign tx_cnt   = tx_cnt_q;
  assign rx_cnt   = rx_cnt_q;

endmodule

// File: tb/tb_nic_port_scheduler.sv
// Testbench for nic_port_scheduler: a behavioural NIC model answers the
// scheduler's strobes, directed scenarios check cycle timing, and a random
// run compares NIC writes and received packets against in-order queues.

module tb_nic_port_scheduler;

  localparam int PW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sched_en;
  logic          tx_valid;
  logic [PW-1:0] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          rx_ready;
  logic [1:0]    nic_addr;
  logic          nicEn;
  logic          nicEnWR;
  logic [PW-1:0] nic_d_in;
  logic [PW-1:0] nic_d_out = '0;
  logic          busy;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nic_port_scheduler #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nicEn(nicEn), .nicEnWR(nicEnWR),
    .nic_d_in(nic_d_in), .nic_d_out(nic_d_out), .busy(busy),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  // NIC environment model
  logic [PW-1:0] in_fifo[$];
  logic [PW-1:0] wr_log[$];
  logic [1:0]    req_log[$];
  int            out_full_cnt = 0;
  bit            out_rand = 0;
  int            cnt_rd11 = 0, cnt_rd01 = 0, cnt_rd00 = 0, cnt_wr10 = 0, cnt_txr = 0;
  int            rd11_at_wr = -1;
  int            proto_err = 0, dinerr = 0;
  bit            wr_allowed = 0;
  logic          st_bit;
  logic [PW-1:0] rnd_word;

  always @(posedge clk) begin
    rnd_word = {$urandom, $urandom};
    if (tx_ready) cnt_txr++;
    if (!(nicEn && nicEnWR) && nic_d_in !== '0) dinerr++;
    if (nicEn && nicEnWR) begin
      if (nic_addr == 2'b10) begin
        wr_log.push_back(nic_d_in);
        cnt_wr10++;
        if (cnt_wr10 == 1) rd11_at_wr = cnt_rd11;
        if (!wr_allowed) proto_err++;
        wr_allowed = 0;
      end else begin
        proto_err++;
      end
    end else if (nicEn) begin
      case (nic_addr)
        2'b11: begin
          if (out_rand) st_bit = 1'($urandom_range(0, 1));
          else st_bit = (out_full_cnt > 0);
          if (out_full_cnt > 0) out_full_cnt--;
          wr_allowed = !st_bit;
          nic_d_out <= {rnd_word[PW-1:1], st_bit};
          cnt_rd11++;
          req_log.push_back(2'b11);
        end
        2'b01: begin
          st_bit = (in_fifo.size() > 0);
          nic_d_out <= {rnd_word[PW-1:1], st_bit};
          cnt_rd01++;
          req_log.push_back(2'b01);
        end
        2'b00: begin
          if (in_fifo.size() > 0) nic_d_out <= in_fifo.pop_front();
          else nic_d_out <= rnd_word;
          cnt_rd00++;
        end
        default: proto_err++;
      endcase
    end
  end

  task automatic do_reset();
    reset    = 1'b0;
    sched_en = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    in_fifo.delete();
    wr_log.delete();
    req_log.delete();
    out_full_cnt = 0;
    out_rand     = 0;
    cnt_rd11 = 0; cnt_rd01 = 0; cnt_rd00 = 0; cnt_wr10 = 0; cnt_txr = 0;
    rd11_at_wr = -1;
    proto_err = 0; dinerr = 0; wr_allowed = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sched_en = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({nicEn, nicEnWR, nic_addr, tx_ready, busy} !== 6'b0) begin
      n_err++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {nicEn, nicEnWR, nic_addr, tx_ready, busy});
    end
    n_cmp++;
    if ({rx_valid, rx_data, nic_d_in} !== '0) begin
      n_err++; $display("[TB] FAIL reset_data: rx_valid=%b rx_data=%h nic_d_in=%h expected all 0", rx_valid, rx_data, nic_d_in);
    end
    n_cmp++;
    if (tx_cnt !== 0 || rx_cnt !== 0) begin
      n_err++; $display("[TB] FAIL reset_cnt: tx_cnt=%0d rx_cnt=%0d expected 0", tx_cnt, rx_cnt);
    end
  endtask

  task automatic test_tx_single();
    logic [PW-1:0] pkt;
    pkt = 64'hDEAD_BEEF_0000_0001;
    do_reset();
    tx_data = pkt; tx_valid = 1'b1; sched_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({nicEn, nicEnWR, nic_addr} !== 4'b1011) begin
      n_err++; $display("[TB] FAIL tx_cycle1: got %b expected 1011", {nicEn, nicEnWR, nic_addr});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({nicEn, nicEnWR, nic_addr, tx_ready} !== 5'b11101) begin
      n_err++; $display("[TB] FAIL tx_cycle3: got %b expected 11101", {nicEn, nicEnWR, nic_addr, tx_ready});
    end
    n_cmp++;
    if (nic_d_in !== pkt) begin
      n_err++; $display("[TB] FAIL tx_data: got %h expected %h", nic_d_in, pkt);
    end
    tx_valid = 1'b0; sched_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx_cnt !== 1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL tx_done: tx_cnt=%0d busy=%b tx_ready=%b expected 1 0 0", tx_cnt, busy, tx_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    do_reset();
    tx_data = 64'h1111_2222_3333_4444; tx_valid = 1'b1; sched_en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL midwr_in_owr: tx_ready=%b expected 1", tx_ready);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({nicEn, tx_ready, busy} !== 3'b000 || nic_d_in !== '0 || tx_cnt !== 0 || rx_cnt !== 0) begin
      n_err++; $display("[TB] FAIL midwr_reset: en/rdy/busy=%b d_in=%h tx_cnt=%0d rx_cnt=%0d expected 0", {nicEn, tx_ready, busy}, nic_d_in, tx_cnt, rx_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (nicEn) found = 1;
    end
    n_cmp++;
    if (!found || nic_addr !== 2'b11 || nicEnWR !== 1'b0) begin
      n_err++; $display("[TB] FAIL midwr_first_strobe: found=%0d addr=%b wr=%b expected addr 11 read", found, nic_addr, nicEnWR);
    end
    tx_valid = 1'b0; sched_en = 1'b0;
  endtask

  task automatic test_tx_backpressure();
    bit found;
    logic [PW-1:0] pkt;
    do_reset();
    pkt = {$urandom, $urandom};
    out_full_cnt = 3;
    tx_data = pkt; tx_valid = 1'b1; sched_en = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (tx_ready) found = 1;
    end
    tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (!found || rd11_at_wr !== 4) begin
      n_err++; $display("[TB] FAIL bp_polls: found=%0d polls_before_write=%0d expected 4", found, rd11_at_wr);
    end
    n_cmp++;
    if (cnt_wr10 !== 1 || cnt_txr !== 1 || tx_cnt !== 1) begin
      n_err++; $display("[TB] FAIL bp_single_write: writes=%0d pulses=%0d tx_cnt=%0d expected 1", cnt_wr10, cnt_txr, tx_cnt);
    end
    n_cmp++;
    if (wr_log.size() != 1 || wr_log[0] !== pkt) begin
      n_err++; $display("[TB] FAIL bp_data: log_size=%0d expected 1 with %h", wr_log.size(), pkt);
    end
    sched_en = 1'b0;
  endtask

  task automatic test_rx_hold();
    logic [PW-1:0] pkt;
    int s01, s00;
    bit found;
    pkt = 64'h0123_4567_89AB_CDEF;
    do_reset();
    in_fifo.push_back(pkt);
    sched_en = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("[TB] FAIL rx_cycle4: rx_valid=%b busy=%b expected 0 1", rx_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== pkt || rx_cnt !== 1) begin
      n_err++; $display("[TB] FAIL rx_cycle5: rx_valid=%b data=%h cnt=%0d expected 1 %h 1", rx_valid, rx_data, rx_cnt, pkt);
    end
    s01 = cnt_rd01; s00 = cnt_rd00;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cnt_rd01 != s01 || cnt_rd00 != s00 || busy !== 1'b0 || rx_valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL rx_hold: new01=%0d new00=%0d busy=%b rx_valid=%b expected 0 0 0 1", cnt_rd01 - s01, cnt_rd00 - s00, busy, rx_valid);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL rx_consume: rx_valid=%b expected 0", rx_valid);
    end
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (cnt_rd01 > s01) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("[TB] FAIL rx_resume: input polls=%0d expected >0", cnt_rd01 - s01);
    end
    sched_en = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq[4];
    bit found;
    exp_seq = '{2'b11, 2'b01, 2'b11, 2'b01};
    do_reset();
    for (int i = 0; i < 8; i++) in_fifo.push_back({$urandom, $urandom});
    tx_data = {$urandom, $urandom};
    tx_valid = 1'b1; rx_ready = 1'b1; sched_en = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (req_log.size() >= 4) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("[TB] FAIL rr_timeout: polls=%0d expected 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (req_log[i] !== exp_seq[i]) begin
          n_err++; $display("[TB] FAIL rr_order[%0d]: got addr %b expected %b", i, req_log[i], exp_seq[i]);
        end
      end
    end
    tx_valid = 1'b0; rx_ready = 1'b0; sched_en = 1'b0;
  endtask

  task automatic test_sched_en_drop();
    int s;
    bit active, found;
    do_reset();
    in_fifo.push_back(64'hCAFE_F00D_1234_5678);
    sched_en = 1'b1;
    repeat (2) @(negedge clk);
    sched_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({nicEn, nic_addr} !== 3'b100) begin
      n_err++; $display("[TB] FAIL en_drop_breq: got %b expected 100", {nicEn, nic_addr});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rx_cnt !== 1 || rx_valid !== 1'b1 || rx_data !== 64'hCAFE_F00D_1234_5678) begin
      n_err++; $display("[TB] FAIL en_drop_capture: rx_cnt=%0d rx_valid=%b data=%h expected 1 1 cafef00d12345678", rx_cnt, rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    s = cnt_rd11 + cnt_rd01 + cnt_rd00 + cnt_wr10;
    active = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_ready = 1'b0;
      if (nicEn || busy) active = 1;
    end
    n_cmp++;
    if (active || (cnt_rd11 + cnt_rd01 + cnt_rd00 + cnt_wr10) != s) begin
      n_err++; $display("[TB] FAIL en_drop_idle: activity=%0d new_strobes=%0d expected 0", active, cnt_rd11 + cnt_rd01 + cnt_rd00 + cnt_wr10 - s);
    end
    sched_en = 1'b1;
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clk);
      if (nicEn) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("[TB] FAIL en_restart: no strobe after sched_en=1");
    end
    sched_en = 1'b0;
  endtask

  task automatic test_random();
    logic [PW-1:0] exp_tx[$];
    logic [PW-1:0] exp_rx[$];
    logic [PW-1:0] w, e, p;
    int  tx_written, rx_got;
    bit  drained, rdy;
    do_reset();
    out_rand = 1;
    tx_written = 0; rx_got = 0; drained = 0;
    for (int cyc = 0; cyc < 3500 && !drained; cyc++) begin
      @(negedge clk);
      while (wr_log.size() > 0) begin
        w = wr_log.pop_front();
        tx_written++;
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_err++; $display("[TB] FAIL rand_tx_extra: got %h expected no write", w);
        end else begin
          e = exp_tx.pop_front();
          if (w !== e) begin
            n_err++; $display("[TB] FAIL rand_tx_data: got %h expected %h", w, e);
          end
        end
      end
      rdy = (cyc >= 3000) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rx_valid && rdy) begin
        rx_got++;
        n_cmp++;
        if (exp_rx.size() == 0) begin
          n_err++; $display("[TB] FAIL rand_rx_extra: got %h expected none", rx_data);
        end else begin
          e = exp_rx.pop_front();
          if (rx_data !== e) begin
            n_err++; $display("[TB] FAIL rand_rx_data: got %h expected %h", rx_data, e);
          end
        end
      end
      rx_ready = rdy;
      if (tx_valid && tx_ready) begin
        tx_valid = 1'b0;
      end else if (!tx_valid && cyc < 3000 && $urandom_range(0, 2) == 0) begin
        tx_data = {$urandom, $urandom};
        tx_valid = 1'b1;
        exp_tx.push_back(tx_data);
      end
      if (cyc < 3000 && in_fifo.size() < 3 && $urandom_range(0, 3) == 0) begin
        p = {$urandom, $urandom};
        in_fifo.push_back(p);
        exp_rx.push_back(p);
      end
      sched_en = (cyc >= 3000) ? 1'b1 : ($urandom_range(0, 15) != 0);
      if (cyc > 3000 && !tx_valid && !rx_valid && !busy && exp_tx.size() == 0 && exp_rx.size() == 0) drained = 1;
    end
    n_cmp++;
    if (!drained) begin
      n_err++; $display("[TB] FAIL rand_drain: pending tx=%0d rx=%0d expected 0 0", exp_tx.size(), exp_rx.size());
    end
    n_cmp++;
    if (tx_cnt !== CW'(tx_written) || rx_cnt !== CW'(rx_got)) begin
      n_err++; $display("[TB] FAIL rand_counters: tx_cnt=%0d rx_cnt=%0d expected %0d %0d", tx_cnt, rx_cnt, CW'(tx_written), CW'(rx_got));
    end
    n_cmp++;
    if (proto_err != 0 || dinerr != 0) begin
      n_err++; $display("[TB] FAIL rand_protocol: bad_accesses=%0d stray_d_in=%0d expected 0 0", proto_err, dinerr);
    end
    n_cmp++;
    if (tx_written < 20 || rx_got < 20) begin
      n_err++; $display("[TB] FAIL rand_activity: writes=%0d reads=%0d expected at least 20 each", tx_written, rx_got);
    end
    sched_en = 1'b0; rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_reset_mid_write();
    test_tx_backpressure();
    test_rx_hold();
    test_round_robin();
    test_sched_en_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nic_port_scheduler.md
# nic_port_scheduler

Sequencer that owns the CPU-side port of one mesh node's NIC and shares it between a transmit client and a receive client. It polls the NIC output and input status registers, writes outbound packets into the NIC output buffer, and drains inbound packets into a held receive register. Both directions are served round-robin. One instance sits beside each `nic` in a mesh row, in place of direct processor NIC access, for streaming or offload engines.

## Interface
Parameters:
- PACKET_WIDTH, 64, packet and NIC data width
- CNT_WIDTH, 16, width of the packet counters

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- sched_en  in  1  1 = start new transactions; 0 = finish the current one, then idle
- tx_valid  in  1  transmit packet offered
- tx_data  in  PACKET_WIDTH  transmit packet; stable while tx_valid=1 and tx_ready=0
- tx_ready  out  1  one-cycle accept pulse; tx_data is written to the NIC in that cycle
- rx_valid  out  1  receive register holds a packet
- rx_data  out  PACKET_WIDTH  received packet
- rx_ready  in  1  receive client consumes the packet when rx_valid=1
- nic_addr  out  2  00 input buffer, 01 input status, 10 output buffer, 11 output status
- nicEn  out  1  NIC access strobe
- nicEnWR  out  1  1 = write, 0 = read
- nic_d_in  out  PACKET_WIDTH  write data to the NIC
- nic_d_out  in  PACKET_WIDTH  NIC read data; valid the cycle after the read strobe
- busy  out  1  state is not IDLE
- tx_cnt, rx_cnt  out  CNT_WIDTH  packets written to and read from the NIC; wrap modulo 2^CNT_WIDTH

## Operation
- Status bit: nic_d_out[0]. Output status 1 means the output buffer is full. Input status 1 means the input buffer holds a packet.
- States: IDLE, O_REQ, O_CHK, O_WR, I_REQ, I_CHK, B_REQ, B_CAP.
- Eligibility:
  - tx_elig = tx_valid.
  - rx_elig = !rx_valid.
- IDLE:
  - If sched_en=0 or neither side is eligible, stay in IDLE.
  - If only one side is eligible, take that side.
  - If both are eligible, take the side opposite last_served.
  - Tx goes to O_REQ; rx goes to I_REQ.
- Transmit path:
  - O_REQ: nicEn=1, nicEnWR=0, addr=11; go to O_CHK.
  - O_CHK:
    - Set last_served=tx.
    - If tx_valid=1 and status=0, go to O_WR.
    - Otherwise go to IDLE with no write.
  - O_WR: nicEn=1, nicEnWR=1, addr=10, nic_d_in=tx_data, tx_ready=1; tx_cnt+1; go to IDLE.
- Receive path:
  - I_REQ: nicEn=1, nicEnWR=0, addr=01; go to I_CHK.
  - I_CHK: set last_served=rx. If status=1, go to B_REQ; otherwise go to IDLE.
  - B_REQ: read with addr=00; the NIC clears its input status on this read. Go to B_CAP.
  - B_CAP: rx_data<=nic_d_out, rx_valid<=1, rx_cnt+1; go to IDLE.
- rx_valid clears on any edge where rx_valid=1 and rx_ready=1, independent of state. While rx_valid=1 the input side is never polled, so the NIC input buffer provides back-pressure.
- Outputs are decoded from the state register only, with no combinational path from inputs:
  - nicEn, nicEnWR, nic_addr and tx_ready depend on state alone.
  - nic_d_in equals tx_data in O_WR and 0 in every other state.
- sched_en is sampled only in IDLE. Deasserting it never aborts a transaction.
- Reset, asynchronous at any point including mid-write:
  - State = IDLE, last_served = rx, so tx wins the first tie.
  - rx_valid = 0, rx_data = 0, tx_cnt = 0, rx_cnt = 0.
  - Every output = 0.

## Timing
- A transmit transaction takes 4 cycles: IDLE, O_REQ, O_CHK, O_WR.
- With tx_valid seen in IDLE at cycle 0, tx_ready pulses at cycle 3.
- A receive transaction takes 5 cycles. rx_valid is high from cycle 5, the edge after B_CAP.
- A failed status poll costs 3 cycles: IDLE, *_REQ, *_CHK, then back to IDLE.
- The NIC sees at most one strobe per cycle, and there are no back-to-back writes without a status read between them.
- Simultaneous rx consume and B_CAP capture cannot occur, because B_CAP is entered only when rx_valid=0.
- Counters wrap from all-ones to 0 with no saturation.

## Test plan
- Reset mid-O_WR: drive reset=0 → same cycle, nicEn=0, tx_ready=0, busy=0, counters 0. After release with tx_valid=1, the first strobe is addr=11.
- Transmit with 64'hDEAD_BEEF_0000_0001 and output status 0 → cycle 1: nicEn=1, addr=11, WR=0. Cycle 3: addr=10, WR=1, nic_d_in=64'hDEAD_BEEF_0000_0001, tx_ready=1. tx_cnt=1.
- Output status held at 1 for 3 polls, then 0 → three 3-cycle polls with no write and tx_ready=0, then exactly one write. tx_cnt=1.
- Input status 1 with buffer 64'h0123_4567_89AB_CDEF → rx_valid=1 at cycle 5 with that data. Hold rx_ready=0 for 10 cycles with tx idle → no addr 01/00 strobes. One cycle of rx_ready=1 → rx_valid=0 and polling resumes.
- Both sides pending continuously after reset → service order tx, rx, tx, rx, checked by O_REQ/I_REQ strobes.
- Deassert sched_en during I_CHK with input status 1 → B_REQ and B_CAP complete and rx_cnt=1. Afterwards nicEn stays 0 and busy=0 until sched_en=1.
